top: RTL and testbench



---
 rtl/top.sv | 88 ++++++++
 tb/tb_top.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Dual-mode 8-bit code converter: binary->Gray in one step, Gray->binary serially MSB-first.
// Result is held on data_out and announced by a one-cycle done pulse.
module top (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       convert,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] op;
   logic [7:0] res;
   logic [7:0] res_next;
   logic       mode;
   logic [2:0] idx;
   logic       capture;
   logic       calc_step;
   logic       load_out;
   logic       prev_bit;

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = CALC;
         CALC: if (!mode || idx == 3'd0) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // control decode and next result; the bit above the MSB is treated as 0
   always_comb begin
      capture   = (state == IDLE) && start;
      calc_step = (state == CALC);
      load_out  = (state == CALC) && (!mode || idx == 3'd0);
      prev_bit  = (idx == 3'd7) ? 1'b0 : res[idx + 3'd1];
      res_next  = res;
      if (!mode) begin
         res_next = op ^ (op >> 1);
      end else begin
         res_next[idx] = prev_bit ^ op[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op       <= 8'h00;
         res      <= 8'h00;
         mode     <= 1'b0;
         idx      <= 3'd7;
         data_out <= 8'h00;
         done     <= 1'b0;
      end else begin
         done <= load_out;
         if (capture) begin
            op   <= data_in;
            mode <= convert;
            res  <= 8'h00;
            idx  <= 3'd7;
         end else if (calc_step) begin
            res <= res_next;
            if (mode) idx <= idx - 3'd1;
         end
         if (load_out) data_out <= res_next;
      end
   end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the code converter: driver pushes expected result and done cycle,
// a negedge monitor pops and checks on done and checks data_out hold otherwise.
module tb_top;

   logic       clk;
   logic       reset;
   logic       start;
   logic       convert;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       done;

   logic [7:0] exp_q[$];
   int         cyc_q[$];
   int         checks = 0;
   int         fails = 0;
   int         cyc = 0;
   logic       rst_d = 1'b1;
   logic       done_d = 1'b0;
   logic [7:0] hold_val = 8'h00;

   top dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .convert(convert),
      .data_in(data_in),
      .data_out(data_out),
      .done(done)
   );

   // clock / reset-tracking block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_d <= reset;
   end

   function automatic logic [7:0] g2b(input logic [7:0] g);
      logic [7:0] b;
      b[7] = g[7];
      for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (cyc > 0) begin
         if (rst_d) begin
            checks++;
            if (data_out !== 8'h00 || done !== 1'b0) begin
               fails++;
               $display("FAIL reset_state: data_out=%h done=%b, required data_out=00 done=0", data_out, done);
            end
            hold_val = 8'h00;
         end else begin
            if (done_d) begin
               checks++;
               if (done !== 1'b0) begin
                  fails++;
                  $display("FAIL done_width: done=%b at cycle %0d, required 0", done, cyc);
               end
            end
            if (done === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_done: data_out=%h at cycle %0d, required no done", data_out, cyc);
               end else begin
                  logic [7:0] e;
                  int         c;
                  e = exp_q.pop_front();
                  c = cyc_q.pop_front();
                  if (data_out !== e) begin
                     fails++;
                     $display("FAIL result: data_out=%h, required %h", data_out, e);
                  end
                  checks++;
                  if (cyc != c) begin
                     fails++;
                     $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, c);
                  end
                  hold_val = e;
               end
            end else begin
               checks++;
               if (data_out !== hold_val) begin
                  fails++;
                  $display("FAIL hold: data_out=%h, required %h", data_out, hold_val);
               end
            end
         end
         done_d <= done;
      end
   end

   // driver: start is raised at a negedge so the next posedge is the capture edge E0
   task automatic issue(input logic conv, input logic [7:0] din, input logic [7:0] exp, input bit chk);
      @(negedge clk);
      start   = 1'b1;
      convert = conv;
      data_in = din;
      @(posedge clk);
      #1;
      if (chk) begin
         exp_q.push_back(exp);
         cyc_q.push_back(cyc + (conv ? 8 : 1));
      end
      start   = 1'b0;
      convert = $urandom_range(0, 1);
      data_in = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL timeout: %0d results pending, required 0", exp_q.size());
         exp_q.delete();
         cyc_q.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run(input logic conv, input logic [7:0] din, input logic [7:0] exp);
      issue(conv, din, exp, 1'b1);
      wait_done();
   endtask

   logic [7:0] b2g_in[6]  = '{8'h00, 8'h01, 8'h0F, 8'h55, 8'hA3, 8'hFF};
   logic [7:0] b2g_out[6] = '{8'h00, 8'h01, 8'h08, 8'h7F, 8'hF2, 8'h80};
   logic [7:0] g2b_in[6]  = '{8'h00, 8'h01, 8'h08, 8'h7F, 8'hF2, 8'h80};
   logic [7:0] g2b_out[6] = '{8'h00, 8'h01, 8'h0F, 8'h55, 8'hA3, 8'hFF};

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      convert = 1'b0;
      data_in = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) run(1'b0, b2g_in[i], b2g_out[i]);
      for (int i = 0; i < 6; i++) run(1'b1, g2b_in[i], g2b_out[i]);

      for (int i = 0; i < 5; i++) begin
         logic [7:0] x;
         x = 8'($urandom_range(0, 255));
         run(1'b0, x, x ^ (x >> 1));
         x = 8'($urandom_range(0, 255));
         run(1'b1, x, g2b(x));
      end

      // start and operand changes during CALC must be ignored
      issue(1'b1, 8'h7F, 8'h55, 1'b1);
      @(negedge clk);
      start   = 1'b1;
      convert = 1'b0;
      data_in = 8'h00;
      repeat (5) @(negedge clk);
      start = 1'b0;
      wait_done();

      // reset in the 4th CALC cycle aborts without a done pulse
      issue(1'b1, 8'h55, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      run(1'b1, 8'hF2, 8'hA3);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
